// File: rtl/rotary_pkg.sv
// Shared constants for the rotary encoder front end and the digit decoder.
// DIGIT_W is the digit bus width; MAX_COUNT_DEF is the default top digit.
package rotary_pkg;

   localparam int DIGIT_W       = 4;
   localparam int MAX_COUNT_DEF = 9;
   localparam int DB_CNT_W      = 8;

endpackage

// File: rtl/debounce.sv
// Two-flop synchronizer followed by a stable-sample filter.
// Ports: clk, rst_n (sync, active-low), raw_i (async raw), filt_o (filtered).
module debounce
   import rotary_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic filt_o
);

   localparam logic [DB_CNT_W-1:0] LAST =
      DB_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic                s1_q, s2_q;
   logic                filt_q, filt_d;
   logic [DB_CNT_W-1:0] cnt_q, cnt_d;

   // Every differing sample counts; the last one in a
   // run of DEBOUNCE_CYCLES commits the new level.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (s2_q != filt_q) begin
         if (cnt_q == LAST) begin
            filt_d = s2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         filt_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         s1_q   <= raw_i;
         s2_q   <= s1_q;
         filt_q <= filt_d;
         cnt_q  <= cnt_d;
      end
   end

   assign filt_o = filt_q;

endmodule

// File: rtl/rotary_counter.sv
// Quadrature encoder + push-button to a wrapping decimal digit.
// Ports: clk, rst_n, enc_a, enc_b, btn in; counter, step_up, step_dn, err out.
module rotary_counter
   import rotary_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int MAX_COUNT       = MAX_COUNT_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enc_a,
   input  logic               enc_b,
   input  logic               btn,
   output logic [DIGIT_W-1:0] counter,
   output logic               step_up,
   output logic               step_dn,
   output logic               err
);

   localparam logic [DIGIT_W-1:0] MAX_C = DIGIT_W'(MAX_COUNT);

   logic filt_a, filt_b, filt_btn;
   logic prev_a_q, prev_b_q, prev_btn_q;
   logic chg_a, chg_b, rise_a, illegal, press;
   logic up, dn;

   logic [DIGIT_W-1:0] cnt_q, cnt_d;
   logic               up_q, up_d;
   logic               dn_q, dn_d;
   logic               err_q;

   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (enc_a),
      .filt_o (filt_a)
   );

   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (enc_b),
      .filt_o (filt_b)
   );

   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_btn (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (btn),
      .filt_o (filt_btn)
   );

   assign chg_a   = filt_a ^ prev_a_q;
   assign chg_b   = filt_b ^ prev_b_q;
   assign rise_a  = filt_a & ~prev_a_q;
   assign illegal = chg_a & chg_b;
   assign press   = filt_btn & ~prev_btn_q;

   // One step per detent, taken on the A rising edge;
   // B's level at that moment gives the direction.
   assign up = rise_a & ~filt_b & ~illegal;
   assign dn = rise_a &  filt_b & ~illegal;

   always_comb begin
      cnt_d = cnt_q;
      up_d  = 1'b0;
      dn_d  = 1'b0;
      if (press) begin
         cnt_d = '0;
      end else if (up) begin
         cnt_d = (cnt_q >= MAX_C) ? '0 : cnt_q + 1'b1;
         up_d  = 1'b1;
      end else if (dn) begin
         cnt_d = (cnt_q == '0) ? MAX_C : cnt_q - 1'b1;
         dn_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_a_q   <= 1'b0;
         prev_b_q   <= 1'b0;
         prev_btn_q <= 1'b0;
         cnt_q      <= '0;
         up_q       <= 1'b0;
         dn_q       <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         prev_a_q   <= filt_a;
         prev_b_q   <= filt_b;
         prev_btn_q <= filt_btn;
         cnt_q      <= cnt_d;
         up_q       <= up_d;
         dn_q       <= dn_d;
         err_q      <= illegal;
      end
   end

   assign counter = cnt_q;
   assign step_up = up_q;
   assign step_dn = dn_q;
   assign err     = err_q;

endmodule
